// File: rtl/param_sched_pkg.sv
// Shared types and default constants for the parameter update scheduler.
// Slot index width is fixed at 4 bits, which covers up to 16 parameter slots.
package param_sched_pkg;

  localparam int SLOT_W     = 4;
  localparam int DATA_W     = 32;
  localparam int DEF_NPARAM = 7;

  // Trigger bit per slot, slot 0 in the least significant nibble.
  localparam logic [DEF_NPARAM*4-1:0] DEF_TRIG_MAP =
    {4'd7, 4'd9, 4'd13, 4'd14, 4'd15, 4'd5, 4'd4};

  localparam logic [DEF_NPARAM*DATA_W-1:0] DEF_RESET_VALS =
    {32'h0, 32'h3f8ccccd, 32'h3c5844d0, 32'h3d144674,
     32'h3e714120, 32'h42a00000, 32'h42a00000};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [DATA_W-1:0] data;
  } upd_entry_t;

endpackage

// File: rtl/param_fifo.sv
// Synchronous FIFO holding pending slot updates; a push into a full queue is
// accepted only when a pop happens on the same edge.
module param_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_global,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_pushData,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_popData,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_doPop   = i_pop && (r_count != '0);
  assign w_doPush  = i_push && (!o_full || w_doPop);
  assign o_popData = r_mem[r_rdPtr];
  assign o_count   = r_count;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/param_update_sched.sv
// Queues triggered parameter updates and applies them as one burst per tick,
// one slot write per cycle, into a bank of 32-bit parameter registers.
module param_update_sched
  import param_sched_pkg::*;
#(
  parameter int                   NPARAM     = 7,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [NPARAM*4-1:0]  TRIG_MAP   = DEF_TRIG_MAP,
  parameter logic [NPARAM*32-1:0] RESET_VALS = DEF_RESET_VALS
) (
  input  logic                        clk,
  input  logic                        reset_global,
  input  logic [15:0]                 trig_in,
  input  logic [31:0]                 data_in,
  input  logic                        tick,
  output logic [NPARAM*32-1:0]        param_out,
  output logic                        update_done,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic                        overflow,
  output logic                        late_tick
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e          r_state;
  sched_state_e          w_nextState;
  logic [NPARAM-1:0]     w_hit;
  logic [SLOT_W-1:0]     w_hitSlot;
  logic                  w_anyHit;
  logic                  w_multiHit;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_lastPop;
  logic                  w_startBurst;
  logic                  w_dropFull;
  logic [CW-1:0]         w_count;
  upd_entry_t            w_pushEntry;
  upd_entry_t            w_popEntry;
  logic [CW-1:0]         r_remain;
  logic                  r_wrValid;
  logic                  r_wrLast;
  upd_entry_t            r_wr;
  logic [NPARAM*32-1:0]  r_bank;
  logic                  r_updateDone;
  logic                  r_overflow;
  logic                  r_lateTick;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NPARAM; k++) begin
      w_hit[k] = trig_in[TRIG_MAP[k*4 +: 4]];
    end
  end

  // Lowest-numbered slot wins when several mapped triggers fire together.
  always_comb begin
    w_hitSlot = '0;
    for (int k = NPARAM-1; k >= 0; k--) begin
      if (w_hit[k]) w_hitSlot = SLOT_W'(k);
    end
  end

  assign w_anyHit    = |w_hit;
  assign w_multiHit  = |(w_hit & (w_hit - NPARAM'(1)));
  assign w_dropFull  = w_anyHit && w_full && !w_pop;
  assign w_pushEntry = '{slot: w_hitSlot, data: data_in};

  param_fifo #(
    .WIDTH ($bits(upd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_global (reset_global),
    .i_push       (w_anyHit),
    .i_pushData   (w_pushEntry),
    .i_pop        (w_pop),
    .o_popData    (w_popEntry),
    .o_count      (w_count),
    .o_full       (w_full)
  );

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) r_state <= ST_IDLE;
    else              r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_pop        = 1'b0;
    w_lastPop    = 1'b0;
    w_startBurst = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tick && (w_count != '0)) begin
          w_startBurst = 1'b1;
          w_nextState  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_pop = 1'b1;
        if (r_remain == CW'(1)) begin
          w_lastPop   = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Burst length is frozen at the tick, so later arrivals wait for the next one.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global)      r_remain <= '0;
    else if (w_startBurst) r_remain <= w_count;
    else if (w_pop)        r_remain <= r_remain - CW'(1);
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_wrValid <= 1'b0;
      r_wrLast  <= 1'b0;
      r_wr      <= '0;
    end else begin
      r_wrValid <= w_pop;
      r_wrLast  <= w_lastPop;
      if (w_pop) r_wr <= w_popEntry;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_bank       <= RESET_VALS;
      r_updateDone <= 1'b0;
    end else begin
      r_updateDone <= r_wrValid && r_wrLast;
      if (r_wrValid) begin
        for (int k = 0; k < NPARAM; k++) begin
          if (r_wr.slot == SLOT_W'(k)) r_bank[k*32 +: 32] <= r_wr.data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_overflow <= 1'b0;
      r_lateTick <= 1'b0;
    end else begin
      if (w_multiHit || w_dropFull)     r_overflow <= 1'b1;
      if (tick && (r_state == ST_APPLY)) r_lateTick <= 1'b1;
    end
  end

  assign param_out   = r_bank;
  assign update_done = r_updateDone;
  assign pending     = w_count;
  assign overflow    = r_overflow;
  assign late_tick   = r_lateTick;

endmodule

// File: tb/tb_param_update_sched.sv
// Scoreboard bench: expected slot writes are queued as triggers are driven and
// popped as each write should become visible in the parameter bank.
module tb_param_update_sched;

  localparam logic [223:0] RESET_EXP =
    {32'h0, 32'h3f8ccccd, 32'h3c5844d0, 32'h3d144674,
     32'h3e714120, 32'h42a00000, 32'h42a00000};
  localparam int MAP [7] = '{4, 5, 15, 14, 13, 9, 7};

  typedef struct {
    int          slot;
    logic [31:0] data;
  } exp_t;

  logic         clk;
  logic         reset_global;
  logic [15:0]  trig_in;
  logic [31:0]  data_in;
  logic         tick;
  logic [223:0] param_out;
  logic         update_done;
  logic [2:0]   pending;
  logic         overflow;
  logic         late_tick;

  int           checks;
  int           failures;
  exp_t         expQ[$];
  logic [223:0] expBank;
  logic         expOvf;

  param_update_sched dut (
    .clk          (clk),
    .reset_global (reset_global),
    .trig_in      (trig_in),
    .data_in      (data_in),
    .tick         (tick),
    .param_out    (param_out),
    .update_done  (update_done),
    .pending      (pending),
    .overflow     (overflow),
    .late_tick    (late_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock cycle of stimulus, entered and left on a falling edge.
  task automatic drive(input logic [15:0] t, input logic [31:0] d, input logic tk);
    trig_in = t;
    data_in = d;
    tick    = tk;
    @(negedge clk);
    trig_in = '0;
    tick    = 1'b0;
  endtask

  task automatic trig(input logic [15:0] mask, input logic [31:0] d);
    int   first;
    int   hits;
    exp_t e;
    first = -1;
    hits  = 0;
    for (int k = 0; k < 7; k++) begin
      if (mask[MAP[k]]) begin
        hits++;
        if (first < 0) first = k;
      end
    end
    if (hits > 1) expOvf = 1'b1;
    if (first >= 0) begin
      if (expQ.size() < 4) begin
        e.slot = first;
        e.data = d;
        expQ.push_back(e);
      end else begin
        expOvf = 1'b1;
      end
    end
    drive(mask, d, 1'b0);
  endtask

  task automatic do_reset();
    reset_global = 1'b1;
    trig_in      = '0;
    data_in      = '0;
    tick         = 1'b0;
    repeat (2) @(negedge clk);
    reset_global = 1'b0;
    @(negedge clk);
    expQ.delete();
    expBank = RESET_EXP;
    expOvf  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (param_out !== RESET_EXP) begin failures++; $display("[TB] FAIL reset_bank got=%h exp=%h", param_out, RESET_EXP); end
    checks++; if (pending !== 3'd0) begin failures++; $display("[TB] FAIL reset_pending got=%0d exp=0", pending); end
    checks++; if (update_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", update_done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (late_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_late got=%b exp=0", late_tick); end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    trig(16'h0010, 32'h42c80000);
    checks++; if (pending !== 3'd1) begin failures++; $display("[TB] FAIL single_pending got=%0d exp=1", pending); end
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL single_early got=%h exp=%h", param_out, expBank); end
    drive('0, '0, 1'b0);
    e = expQ.pop_front();
    expBank[e.slot*32 +: 32] = e.data;
    checks++; if (param_out[31:0] !== 32'h42c80000) begin failures++; $display("[TB] FAIL single_slot0 got=%h exp=42c80000", param_out[31:0]); end
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL single_bank got=%h exp=%h", param_out, expBank); end
    checks++; if (update_done !== 1'b1) begin failures++; $display("[TB] FAIL single_done got=%b exp=1", update_done); end
    drive('0, '0, 1'b0);
    checks++; if (update_done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_pulse got=%b exp=0", update_done); end
    checks++; if (pending !== 3'd0) begin failures++; $display("[TB] FAIL single_pending_after got=%0d exp=0", pending); end
  endtask

  task automatic test_full_overflow();
    exp_t        e;
    logic        expDone;
    logic [15:0] masks [5];
    masks = '{16'h0020, 16'h8000, 16'h4000, 16'h2000, 16'h0200};
    do_reset();
    for (int i = 0; i < 5; i++) trig(masks[i], 32'h1000_0000 + 32'(i));
    checks++; if (pending !== 3'd4) begin failures++; $display("[TB] FAIL full_pending got=%0d exp=4", pending); end
    checks++; if (overflow !== expOvf) begin failures++; $display("[TB] FAIL full_ovf got=%b exp=%b", overflow, expOvf); end
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive('0, '0, 1'b0);
      e = expQ.pop_front();
      expBank[e.slot*32 +: 32] = e.data;
      expDone = (i == 3);
      checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL full_write%0d got=%h exp=%h", i, param_out, expBank); end
      checks++; if (update_done !== expDone) begin failures++; $display("[TB] FAIL full_done%0d got=%b exp=%b", i, update_done, expDone); end
    end
    repeat (2) drive('0, '0, 1'b0);
    checks++; if (param_out[191:160] !== 32'h3f8ccccd) begin failures++; $display("[TB] FAIL full_dropped got=%h exp=3f8ccccd", param_out[191:160]); end
    checks++; if (pending !== 3'd0) begin failures++; $display("[TB] FAIL full_pending_after got=%0d exp=0", pending); end
  endtask

  task automatic test_multi_bit();
    exp_t e;
    do_reset();
    trig(16'h0001, 32'hdead_beef);
    checks++; if (pending !== 3'd0) begin failures++; $display("[TB] FAIL unmapped_pending got=%0d exp=0", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL unmapped_ovf got=%b exp=0", overflow); end
    trig(16'h0030, 32'h4049_0fdb);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL multi_ovf got=%b exp=1", overflow); end
    checks++; if (pending !== 3'd1) begin failures++; $display("[TB] FAIL multi_pending got=%0d exp=1", pending); end
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);
    e = expQ.pop_front();
    expBank[e.slot*32 +: 32] = e.data;
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL multi_bank got=%h exp=%h", param_out, expBank); end
    checks++; if (param_out[63:32] !== 32'h42a00000) begin failures++; $display("[TB] FAIL multi_slot1 got=%h exp=42a00000", param_out[63:32]); end
    checks++; if (update_done !== 1'b1) begin failures++; $display("[TB] FAIL multi_done got=%b exp=1", update_done); end
  endtask

  task automatic test_enqueue_during_apply();
    exp_t e;
    logic expDone;
    do_reset();
    trig(16'h0010, 32'h0000_0a01);
    trig(16'h8000, 32'h0000_0a02);
    trig(16'h0200, 32'h0000_0a03);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL apply_early got=%h exp=%h", param_out, expBank); end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) trig(16'h4000, 32'h0000_0a04);
      else        drive('0, '0, 1'b0);
      e = expQ.pop_front();
      expBank[e.slot*32 +: 32] = e.data;
      expDone = (i == 2);
      checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL apply_write%0d got=%h exp=%h", i, param_out, expBank); end
      checks++; if (update_done !== expDone) begin failures++; $display("[TB] FAIL apply_done%0d got=%b exp=%b", i, update_done, expDone); end
    end
    checks++; if (pending !== 3'd1) begin failures++; $display("[TB] FAIL apply_pending got=%0d exp=1", pending); end
    repeat (2) drive('0, '0, 1'b0);
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL apply_no_extra got=%h exp=%h", param_out, expBank); end
    checks++; if (update_done !== 1'b0) begin failures++; $display("[TB] FAIL apply_no_done got=%b exp=0", update_done); end
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);
    e = expQ.pop_front();
    expBank[e.slot*32 +: 32] = e.data;
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL apply_fourth got=%h exp=%h", param_out, expBank); end
    checks++; if (update_done !== 1'b1) begin failures++; $display("[TB] FAIL apply_fourth_done got=%b exp=1", update_done); end
  endtask

  task automatic test_late_tick();
    exp_t e;
    logic expDone;
    do_reset();
    trig(16'h0010, 32'h1111_1111);
    trig(16'h0010, 32'h2222_2222);
    trig(16'h8000, 32'h3333_3333);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, (i == 0));
      e = expQ.pop_front();
      expBank[e.slot*32 +: 32] = e.data;
      expDone = (i == 2);
      checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL late_write%0d got=%h exp=%h", i, param_out, expBank); end
      checks++; if (update_done !== expDone) begin failures++; $display("[TB] FAIL late_done%0d got=%b exp=%b", i, update_done, expDone); end
    end
    checks++; if (late_tick !== 1'b1) begin failures++; $display("[TB] FAIL late_flag got=%b exp=1", late_tick); end
    checks++; if (param_out[31:0] !== 32'h2222_2222) begin failures++; $display("[TB] FAIL late_last_wins got=%h exp=22222222", param_out[31:0]); end
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, 1'b0);
      checks++; if (update_done !== 1'b0) begin failures++; $display("[TB] FAIL late_extra_done%0d got=%b exp=0", i, update_done); end
    end
    checks++; if (param_out !== expBank) begin failures++; $display("[TB] FAIL late_bank_after got=%h exp=%h", param_out, expBank); end
    checks++; if (late_tick !== 1'b1) begin failures++; $display("[TB] FAIL late_sticky got=%b exp=1", late_tick); end
  endtask

  task automatic test_reset_mid_apply();
    do_reset();
    trig(16'h0020, 32'h5555_0001);
    trig(16'h8000, 32'h5555_0002);
    trig(16'h4000, 32'h5555_0003);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);
    reset_global = 1'b1;
    #1;
    checks++; if (param_out !== RESET_EXP) begin failures++; $display("[TB] FAIL rstmid_bank got=%h exp=%h", param_out, RESET_EXP); end
    checks++; if (pending !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_pending got=%0d exp=0", pending); end
    checks++; if (update_done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=0", update_done); end
    @(negedge clk);
    reset_global = 1'b0;
    expQ.delete();
    expBank = RESET_EXP;
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive('0, '0, 1'b0);
      checks++; if (param_out !== RESET_EXP) begin failures++; $display("[TB] FAIL rstmid_write%0d got=%h exp=%h", i, param_out, RESET_EXP); end
      checks++; if (update_done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done%0d got=%b exp=0", i, update_done); end
    end
    checks++; if (pending !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_pending_after got=%0d exp=0", pending); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_global = 1'b1;
    trig_in      = '0;
    data_in      = '0;
    tick         = 1'b0;
    expBank      = RESET_EXP;
    expOvf       = 1'b0;
    test_reset();
    test_single();
    test_full_overflow();
    test_multi_bit();
    test_enqueue_during_apply();
    test_late_tick();
    test_reset_mid_apply();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_update_sched.md
PARAM_UPDATE_SCHED -- requirements
Module: param_update_sched

Interface
REQ-001 SHALL have parameter NPARAM, default 7, meaning number of 32-bit parameter slots.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning pending-update queue depth (power of 2).
REQ-003 SHALL have parameter TRIG_MAP, default {4'd7,4'd9,4'd13,4'd14,4'd15,4'd5,4'd4}, meaning 4-bit trigger-bit index per slot, where slot 0 occupies bits [3:0].
REQ-004 SHALL have parameter RESET_VALS, default {32'h0,32'h3f8ccccd,32'h3c5844d0,32'h3d144674,32'h3e714120,32'h42a00000,32'h42a00000}, meaning the reset value of each slot, where slot 0 occupies bits [31:0].
REQ-005 clk  input  1  fast system clock (clk1).
REQ-006 reset_global  input  1  reset, asynchronous, active-high.
REQ-007 trig_in  input  16  one-cycle trigger pulses, clk domain.
REQ-008 data_in  input  32  update value, sampled with trig_in.
REQ-009 tick  input  1  one-cycle strobe per simulation step (1 ms), clk domain.
REQ-010 param_out  output  NPARAM*32  applied parameter bank; slot k at [k*32 +: 32].
REQ-011 update_done  output  1  one-cycle pulse after each apply burst completes.
REQ-012 pending  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-013 overflow  output  1  sticky flag: an update was dropped.
REQ-014 late_tick  output  1  sticky flag: a tick arrived during APPLY.

Function
REQ-015 A trig_in bit that appears in TRIG_MAP SHALL enqueue {slot, data_in} at the clk edge where it is seen; unmapped bits SHALL be ignored.
REQ-016 When several mapped bits are set in one cycle, the lowest-numbered slot SHALL be enqueued and the remaining slots SHALL be dropped, setting overflow.
REQ-017 An enqueue while the queue is full (pending==FIFO_DEPTH) SHALL be dropped and SHALL set overflow; the queue contents SHALL be unchanged.
REQ-018 The FSM SHALL have exactly two states, IDLE and APPLY.
REQ-019 In IDLE, tick with pending>0 SHALL latch burst count N=pending and enter APPLY on the next edge; tick with pending==0 SHALL cause no action.
REQ-020 In APPLY, one entry SHALL be popped per cycle, in FIFO order, and its data written to param_out at its slot; the write SHALL be visible the cycle after the pop.
REQ-021 After N pops the FSM SHALL return to IDLE and pulse update_done for one cycle, coincident with the last write becoming visible.
REQ-022 The first write SHALL be visible 2 cycles after the tick; the last SHALL be visible N+1 cycles after the tick.
REQ-023 Entries enqueued during APPLY SHALL not join the current burst; they SHALL wait for the next tick.
REQ-024 A simultaneous enqueue and pop SHALL both take effect; pending SHALL be unchanged, and a full queue SHALL accept the enqueue.
REQ-025 A tick during APPLY SHALL be ignored, except that it SHALL set late_tick.
REQ-026 Two queued updates to the same slot SHALL apply in order, so the last value wins.
REQ-027 Queue pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 When reset_global is asserted, the block SHALL asynchronously force param_out=RESET_VALS, pending=0, the pointers to 0, state=IDLE, and update_done=overflow=late_tick=0.
REQ-029 A reset asserted during APPLY SHALL abort the burst and discard all queued entries; no partial writes SHALL survive reset.
REQ-030 overflow and late_tick SHALL be cleared only by reset.

Structure
REQ-031 The package param_sched_pkg SHALL hold the state enum, the slot-index width and the default TRIG_MAP/RESET_VALS constants.
REQ-032 The queue SHALL be a sub-module, param_fifo (synchronous FIFO, simultaneous push/pop, count output); the FSM and the bank SHALL reside in the top level.

Verification
REQ-033 The bench SHALL cover: trig_in bit 4 with data 32'h42c80000, then tick → slot 0 = 32'h42c80000 two cycles after the tick, update_done pulses, all other slots keep their reset values.
REQ-034 The bench SHALL cover: 5 distinct triggers with no tick (FIFO_DEPTH=4) → pending=4, overflow=1; after a tick, 4 writes occur over 4 cycles and the 5th value never appears.
REQ-035 The bench SHALL cover: trig_in bits 4 and 5 together with data D → only slot 0 is updated to D and overflow=1.
REQ-036 The bench SHALL cover: 3 entries queued, tick, a new trigger in APPLY cycle 2 → only 3 writes, pending=1 after update_done, and the 4th is applied at the next tick.
REQ-037 The bench SHALL cover: tick during APPLY → late_tick=1 and the burst length is unchanged.
REQ-038 The bench SHALL cover: reset_global pulsed mid-APPLY → param_out equals RESET_VALS immediately, pending=0 and the FSM is in IDLE; a subsequent tick causes no writes.
